// File: rtl/evm_ballot_core.sv
// evm_ballot_core
//   Voting core for an electronic voting machine with NUM_CAND candidates.
//   A polling officer arms the machine for exactly one vote. A button vector
//   must be held stable for HOLD_CYCLES cycles before it counts. Votes with
//   more than one button pressed are rejected. In result mode the core gives
//   per-candidate readback, a sequential winner scan with tie detection, and a
//   saturating total.
//
// Ports
//   clock        rising-edge clock
//   reset        synchronous, active-high; clears all state
//   mode         0 = voting, 1 = result
//   arm          officer pulse enabling one vote
//   button       bit i = candidate i pressed (already synchronised)
//   armed        high while a vote may be cast
//   vote_led     one-cycle pulse when a vote is accepted
//   result       tally of lowest-indexed pressed button (result mode), else 0
//   total        saturating count of all accepted votes
//   winner       index of the highest tally
//   tie          highest tally shared by two or more candidates
//   winner_valid winner/tie are valid
module evm_ballot_core #(
  parameter int NUM_CAND    = 6,
  parameter int CNT_W       = 8,
  parameter int HOLD_CYCLES = 10,
  localparam int IDX_W      = $clog2(NUM_CAND),
  localparam int TOT_W      = CNT_W + IDX_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                mode,
  input  logic                arm,
  input  logic [NUM_CAND-1:0] button,
  output logic                armed,
  output logic                vote_led,
  output logic [CNT_W-1:0]    result,
  output logic [TOT_W-1:0]    total,
  output logic [IDX_W-1:0]    winner,
  output logic                tie,
  output logic                winner_valid
);

  // The hold counter saturates at HOLD_CYCLES so that a held vector only
  // qualifies once, on the cycle the counter sits at HOLD_CYCLES-1.
  localparam int HC_W = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  state_t              state_q;
  logic                armed_q;
  logic                voteLed_q;
  logic [CNT_W-1:0]    tally_q [NUM_CAND];
  logic [TOT_W-1:0]    total_q;

  logic [NUM_CAND-1:0] prev_q;
  logic [HC_W-1:0]     holdCnt_q;
  logic [HC_W-1:0]     holdCnt_d;

  logic                qualified;
  logic                oneHot;
  logic [IDX_W-1:0]    voteIdx;

  logic [IDX_W-1:0]    readIdx;
  logic                readHit;
  logic [CNT_W-1:0]    result_q;
  logic [CNT_W-1:0]    result_d;

  logic                modePrev_q;
  logic                scanning_q;
  logic                scanDone_q;
  logic [IDX_W-1:0]    scanIdx_q;
  logic [CNT_W-1:0]    bestVal_q;
  logic [IDX_W-1:0]    bestIdx_q;
  logic                tieAcc_q;
  logic [CNT_W-1:0]    scanVal;
  logic [IDX_W-1:0]    winner_q;
  logic                tie_q;
  logic                winnerValid_q;

  // Hold counter next state: restarts whenever the vector changes or is
  // released, and is discarded entirely in result mode.
  always_comb begin
    holdCnt_d = holdCnt_q;
    if (mode || (button != prev_q) || (button == '0)) begin
      holdCnt_d = '0;
    end else if (holdCnt_q != HC_W'(HOLD_CYCLES)) begin
      holdCnt_d = holdCnt_q + 1'b1;
    end
  end

  // prev_q is the vector that has been stable for holdCnt_q+1 samples, so it
  // is also the vector that gets counted when qualification fires.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_q    <= '0;
      holdCnt_q <= '0;
    end else begin
      prev_q    <= button;
      holdCnt_q <= holdCnt_d;
    end
  end

  // Qualification and decoding of the stable vector into a candidate index.
  always_comb begin
    qualified = (holdCnt_q == HC_W'(HOLD_CYCLES - 1)) && (prev_q != '0);
    oneHot    = $onehot(prev_q);
    voteIdx   = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (prev_q[i]) voteIdx = IDX_W'(i);
    end
  end

  // Vote FSM with the tallies it owns. Result mode forces DISARMED, which
  // also freezes the tallies because only ARMED can count.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= DISARMED;
      armed_q   <= 1'b0;
      voteLed_q <= 1'b0;
      total_q   <= '0;
      for (int i = 0; i < NUM_CAND; i++) tally_q[i] <= '0;
    end else begin
      voteLed_q <= 1'b0;
      if (mode) begin
        state_q <= DISARMED;
        armed_q <= 1'b0;
      end else begin
        case (state_q)
          DISARMED: begin
            if (arm) begin
              state_q <= ARMED;
              armed_q <= 1'b1;
            end
          end
          ARMED: begin
            if (qualified && oneHot) begin
              if (tally_q[voteIdx] != {CNT_W{1'b1}}) begin
                tally_q[voteIdx] <= tally_q[voteIdx] + 1'b1;
              end
              if (total_q != {TOT_W{1'b1}}) begin
                total_q <= total_q + 1'b1;
              end
              voteLed_q <= 1'b1;
              armed_q   <= 1'b0;
              state_q   <= WAIT_REL;
            end
          end
          WAIT_REL: begin
            if (button == '0) state_q <= DISARMED;
          end
          default: begin
            state_q <= DISARMED;
            armed_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // Readback picks the lowest-indexed pressed button, scanning high to low so
  // the last assignment wins.
  always_comb begin
    readIdx = '0;
    readHit = 1'b0;
    for (int i = NUM_CAND - 1; i >= 0; i--) begin
      if (button[i]) begin
        readIdx = IDX_W'(i);
        readHit = 1'b1;
      end
    end
    result_d = '0;
    if (mode && readHit) result_d = tally_q[readIdx];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign scanVal = tally_q[scanIdx_q];

  // Winner scan: the rising edge of mode starts it, one compare per cycle
  // follows, and a final cycle publishes the result. Strict greater-than
  // keeps the lowest index among equal maxima; a later equal value marks a
  // tie, which a later strictly larger value clears again.
  always_ff @(posedge clock) begin
    if (reset) begin
      modePrev_q    <= 1'b0;
      scanning_q    <= 1'b0;
      scanDone_q    <= 1'b0;
      scanIdx_q     <= '0;
      bestVal_q     <= '0;
      bestIdx_q     <= '0;
      tieAcc_q      <= 1'b0;
      winner_q      <= '0;
      tie_q         <= 1'b0;
      winnerValid_q <= 1'b0;
    end else begin
      modePrev_q <= mode;
      scanDone_q <= 1'b0;
      if (!mode) begin
        scanning_q    <= 1'b0;
        winnerValid_q <= 1'b0;
      end else if (!modePrev_q) begin
        scanning_q    <= 1'b1;
        scanIdx_q     <= '0;
        winnerValid_q <= 1'b0;
      end else if (scanning_q) begin
        if (scanIdx_q == '0) begin
          bestVal_q <= scanVal;
          bestIdx_q <= '0;
          tieAcc_q  <= 1'b0;
        end else if (scanVal > bestVal_q) begin
          bestVal_q <= scanVal;
          bestIdx_q <= scanIdx_q;
          tieAcc_q  <= 1'b0;
        end else if (scanVal == bestVal_q) begin
          tieAcc_q <= 1'b1;
        end
        if (scanIdx_q == IDX_W'(NUM_CAND - 1)) begin
          scanning_q <= 1'b0;
          scanDone_q <= 1'b1;
        end else begin
          scanIdx_q <= scanIdx_q + 1'b1;
        end
      end else if (scanDone_q) begin
        winner_q      <= bestIdx_q;
        tie_q         <= tieAcc_q;
        winnerValid_q <= 1'b1;
      end
    end
  end

  assign armed        = armed_q;
  assign vote_led     = voteLed_q;
  assign result       = result_q;
  assign total        = total_q;
  assign winner       = winner_q;
  assign tie          = tie_q;
  assign winner_valid = winnerValid_q;

endmodule

// File: tb/tb_evm_ballot_core.sv
// tb_evm_ballot_core
//   Directed self-checking bench for evm_ballot_core with NUM_CAND=6,
//   CNT_W=8, HOLD_CYCLES=4. Inputs change 1 time unit after a rising edge and
//   outputs are sampled at the same point, so each tick shows the effect of
//   exactly one clock edge.
module tb_evm_ballot_core;

  localparam int NC = 6;
  localparam int CW = 8;
  localparam int HC = 4;
  localparam int IW = 3;
  localparam int TW = 11;

  logic          clock = 1'b0;
  logic          reset;
  logic          mode;
  logic          arm;
  logic [NC-1:0] button;
  logic          armed;
  logic          vote_led;
  logic [CW-1:0] result;
  logic [TW-1:0] total;
  logic [IW-1:0] winner;
  logic          tie;
  logic          winner_valid;

  int testCount = 0;
  int failCount = 0;
  logic sawPulse;

  evm_ballot_core #(
    .NUM_CAND(NC),
    .CNT_W(CW),
    .HOLD_CYCLES(HC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .mode(mode),
    .arm(arm),
    .button(button),
    .armed(armed),
    .vote_led(vote_led),
    .result(result),
    .total(total),
    .winner(winner),
    .tie(tie),
    .winner_valid(winner_valid)
  );

  always #5 clock = ~clock;

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic m, input logic a, input logic [NC-1:0] b);
    mode   = m;
    arm    = a;
    button = b;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, '0);
    tick(2);
    reset = 1'b0;
  endtask

  // Arm, hold a one-hot button for HOLD_CYCLES samples, release; the pulse
  // appears on the first release edge, and one more edge returns to DISARMED.
  task automatic castVote(input int idx);
    applyStimulus(1'b0, 1'b1, '0);
    tick();
    applyStimulus(1'b0, 1'b0, NC'(1 << idx));
    tick(HC);
    button = '0;
    tick();
    checkOutput("vote_pulse", vote_led, 1);
    tick();
  endtask

  // Enter result mode pressing one button, check the readback, leave again.
  task automatic readTally(input int idx, input int expected);
    applyStimulus(1'b1, 1'b0, NC'(1 << idx));
    tick();
    checkOutput($sformatf("readback_%0d", idx), result, expected);
    applyStimulus(1'b0, 1'b0, '0);
    tick();
  endtask

  initial begin
    // 1: reset state, basic vote with latency HOLD_CYCLES
    applyReset();
    checkOutput("rst_armed", armed, 0);
    checkOutput("rst_vote_led", vote_led, 0);
    checkOutput("rst_result", result, 0);
    checkOutput("rst_total", total, 0);
    checkOutput("rst_winner", winner, 0);
    checkOutput("rst_tie", tie, 0);
    checkOutput("rst_winner_valid", winner_valid, 0);

    applyStimulus(1'b0, 1'b1, '0);
    tick();
    arm = 1'b0;
    checkOutput("t1_armed", armed, 1);
    button = 6'b000100;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checkOutput($sformatf("t1_led_k%0d", k), vote_led, (k == 5) ? 1 : 0);
      if (k == 5) begin
        checkOutput("t1_total", total, 1);
        checkOutput("t1_armed_after", armed, 0);
      end
    end
    button = '0;
    tick();
    button = 6'b000100;
    tick(6);
    checkOutput("t1_no_rearm_total", total, 1);
    checkOutput("t1_disarmed", armed, 0);
    button = '0;
    tick();
    readTally(2, 1);
    readTally(0, 0);

    // 2: press without arm, multi-button rejection, then a change to one-hot
    applyReset();
    button   = 6'b000001;
    sawPulse = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      sawPulse |= vote_led;
    end
    checkOutput("t2_unarmed_pulse", sawPulse, 0);
    checkOutput("t2_unarmed_total", total, 0);
    button = '0;
    tick();
    applyStimulus(1'b0, 1'b1, '0);
    tick();
    applyStimulus(1'b0, 1'b0, 6'b000011);
    sawPulse = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      sawPulse |= vote_led;
    end
    checkOutput("t2_multi_pulse", sawPulse, 0);
    checkOutput("t2_multi_total", total, 0);
    checkOutput("t2_still_armed", armed, 1);
    button = 6'b000010;
    tick(HC);
    checkOutput("t2_led_early", vote_led, 0);
    tick();
    checkOutput("t2_led", vote_led, 1);
    checkOutput("t2_armed_after", armed, 0);
    button = '0;
    tick(2);
    checkOutput("t2_total", total, 1);
    readTally(1, 1);
    readTally(0, 0);

    // 3: short press does not qualify; arm during WAIT_REL is ignored
    applyReset();
    applyStimulus(1'b0, 1'b1, '0);
    tick();
    applyStimulus(1'b0, 1'b0, 6'b000001);
    tick(2);
    button = '0;
    tick();
    button = 6'b000001;
    tick(HC);
    checkOutput("t3_led_early", vote_led, 0);
    tick();
    checkOutput("t3_led", vote_led, 1);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    checkOutput("t3_arm_ignored", armed, 0);
    sawPulse = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      sawPulse |= vote_led;
    end
    checkOutput("t3_no_second_pulse", sawPulse, 0);
    checkOutput("t3_total", total, 1);
    checkOutput("t3_still_disarmed", armed, 0);
    button = '0;
    tick();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    checkOutput("t3_rearm_after_release", armed, 1);

    // 4: tally saturation while total keeps counting
    applyReset();
    for (int v = 0; v < 257; v++) castVote(0);
    checkOutput("t4_total", total, 257);
    readTally(0, 255);
    readTally(1, 0);

    // 5: winner scan with a tie, readback, leaving result mode
    applyReset();
    for (int v = 0; v < 3; v++) castVote(0);
    for (int v = 0; v < 5; v++) castVote(1);
    for (int v = 0; v < 5; v++) castVote(2);
    castVote(3);
    for (int v = 0; v < 2; v++) castVote(5);
    checkOutput("t5_total", total, 16);
    applyStimulus(1'b1, 1'b1, '0);
    tick();
    arm = 1'b0;
    checkOutput("t5_armed_in_result", armed, 0);
    checkOutput("t5_valid_e0", winner_valid, 0);
    tick(NC);
    checkOutput("t5_valid_e6", winner_valid, 0);
    tick();
    checkOutput("t5_valid_e7", winner_valid, 1);
    checkOutput("t5_winner", winner, 1);
    checkOutput("t5_tie", tie, 1);
    button = 6'b100000;
    tick();
    checkOutput("t5_result_5", result, 2);
    button = 6'b101000;
    tick();
    checkOutput("t5_result_lowest", result, 1);
    button = '0;
    tick();
    checkOutput("t5_result_none", result, 0);
    checkOutput("t5_valid_hold", winner_valid, 1);
    mode = 1'b0;
    tick();
    checkOutput("t5_valid_drop", winner_valid, 0);
    checkOutput("t5_result_drop", result, 0);
    checkOutput("t5_disarmed", armed, 0);
    button = 6'b000001;
    tick(6);
    checkOutput("t5_no_vote_disarmed", total, 16);
    button = '0;
    tick();

    // 6: all-zero scan gives winner 0 with tie; reset mid-scan
    applyReset();
    mode = 1'b1;
    tick(NC + 2);
    checkOutput("t6_valid", winner_valid, 1);
    checkOutput("t6_winner", winner, 0);
    checkOutput("t6_tie", tie, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("t6_rst_valid", winner_valid, 0);
    checkOutput("t6_rst_tie", tie, 0);
    tick(3);
    checkOutput("t6_midscan_valid", winner_valid, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("t6_rst2_valid", winner_valid, 0);
    checkOutput("t6_rst2_winner", winner, 0);
    checkOutput("t6_rst2_tie", tie, 0);
    checkOutput("t6_rst2_result", result, 0);
    checkOutput("t6_rst2_total", total, 0);
    checkOutput("t6_rst2_armed", armed, 0);
    checkOutput("t6_rst2_led", vote_led, 0);
    tick(NC + 2);
    checkOutput("t6_rescan_valid", winner_valid, 1);
    checkOutput("t6_rescan_tie", tie, 1);
    mode = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
